// File: rtl/pbus_sequencer_if.sv
// Shared peripheral bus bundle: requester handshakes on one side, W5300/SL811
// bus pins on the other. The sequencer takes the master modport.
interface pbus_sequencer_if;
    logic       req0;
    logic       req1;
    logic       tgt0;
    logic       tgt1;
    logic       rnw0;
    logic       rnw1;
    logic [9:0] addr0;
    logic [9:0] addr1;
    logic [7:0] wdata0;
    logic [7:0] wdata1;
    logic       ack0;
    logic       ack1;
    logic [7:0] rdata;
    logic       busy;
    logic       w5300_cs_n;
    logic       sl811_cs_n;
    logic [9:0] baddr;
    logic       brd_n;
    logic       bwr_n;
    logic [7:0] bd_out;
    logic       bd_oe;
    logic [7:0] bd_in;

    modport master (
        input  req0, req1, tgt0, tgt1, rnw0, rnw1, addr0, addr1, wdata0, wdata1, bd_in,
        output ack0, ack1, rdata, busy, w5300_cs_n, sl811_cs_n, baddr, brd_n, bwr_n,
               bd_out, bd_oe
    );

    modport slave (
        output req0, req1, tgt0, tgt1, rnw0, rnw1, addr0, addr1, wdata0, wdata1, bd_in,
        input  ack0, ack1, rdata, busy, w5300_cs_n, sl811_cs_n, baddr, brd_n, bwr_n,
               bd_out, bd_oe
    );
endinterface

// File: rtl/pbus_sequencer.sv
// pbus_sequencer: round-robin arbiter plus setup/strobe/hold timing engine for
// the bus shared by the W5300 and the SL811. Bus pins are decoded from the
// state and the fields latched at grant, so they cannot glitch between phases.
module pbus_sequencer #(
    parameter int SETUP_CYC    = 1,
    parameter int W_STROBE_CYC = 4,
    parameter int S_STROBE_CYC = 6,
    parameter int HOLD_CYC     = 1
) (
    input  logic             fclk,
    input  logic             rst,
    pbus_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_HOLD   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Counter load values are "cycles - 1": a phase ends when the counter is 0.
    localparam logic [7:0] SETUP_LD = 8'(SETUP_CYC - 1);
    localparam logic [7:0] W_STB_LD = 8'(W_STROBE_CYC - 1);
    localparam logic [7:0] S_STB_LD = 8'(S_STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LD  = 8'(HOLD_CYC - 1);

    state_t     state_reg, state_next;
    logic [7:0] cnt_reg, cnt_next;
    logic       last_reg;
    logic       owner_reg;
    logic       tgt_reg;
    logic       rnw_reg;
    logic [9:0] addr_reg;
    logic [7:0] wdata_reg;
    logic [7:0] rdata_reg;

    logic       gnt_any;
    logic       gnt_sel;
    logic       gnt_tgt;

    // State register, grant-time field latch and end-of-strobe read capture.
    always_ff @(posedge fclk) begin
        if (rst) begin
            state_reg <= S_IDLE;
            cnt_reg   <= 8'd0;
            last_reg  <= 1'b1;
            owner_reg <= 1'b0;
            tgt_reg   <= 1'b0;
            rnw_reg   <= 1'b0;
            addr_reg  <= 10'd0;
            wdata_reg <= 8'd0;
            rdata_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (state_reg == S_IDLE && gnt_any) begin
                owner_reg <= gnt_sel;
                last_reg  <= gnt_sel;
                tgt_reg   <= gnt_sel ? bus.tgt1   : bus.tgt0;
                rnw_reg   <= gnt_sel ? bus.rnw1   : bus.rnw0;
                addr_reg  <= gnt_sel ? bus.addr1  : bus.addr0;
                wdata_reg <= gnt_sel ? bus.wdata1 : bus.wdata0;
            end
            if (state_reg == S_STROBE && cnt_reg == 8'd0 && rnw_reg) begin
                rdata_reg <= bus.bd_in;
            end
        end
    end

    // Arbitration and next-state/counter selection; counter reloads on every phase entry.
    always_comb begin
        gnt_any    = bus.req0 | bus.req1;
        // On a tie the requester that did not own the previous access wins.
        gnt_sel    = (bus.req0 && bus.req1) ? ~last_reg : bus.req1;
        gnt_tgt    = gnt_sel ? bus.tgt1 : bus.tgt0;
        state_next = state_reg;
        cnt_next   = (cnt_reg != 8'd0) ? cnt_reg - 8'd1 : 8'd0;
        case (state_reg)
            S_IDLE: begin
                cnt_next = 8'd0;
                if (gnt_any) begin
                    if (SETUP_CYC > 0) begin
                        state_next = S_SETUP;
                        cnt_next   = SETUP_LD;
                    end else begin
                        state_next = S_STROBE;
                        cnt_next   = gnt_tgt ? S_STB_LD : W_STB_LD;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_reg == 8'd0) begin
                    state_next = S_STROBE;
                    cnt_next   = tgt_reg ? S_STB_LD : W_STB_LD;
                end
            end
            S_STROBE: begin
                if (cnt_reg == 8'd0) begin
                    if (HOLD_CYC > 0) begin
                        state_next = S_HOLD;
                        cnt_next   = HOLD_LD;
                    end else begin
                        state_next = S_DONE;
                        cnt_next   = 8'd0;
                    end
                end
            end
            S_HOLD: begin
                if (cnt_reg == 8'd0) begin
                    state_next = S_DONE;
                    cnt_next   = 8'd0;
                end
            end
            S_DONE: begin
                // Always pass through IDLE so every access gets a fresh arbitration.
                state_next = S_IDLE;
                cnt_next   = 8'd0;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

    // Bus pin and handshake decode from the current phase and latched fields.
    always_comb begin
        bus.w5300_cs_n = 1'b1;
        bus.sl811_cs_n = 1'b1;
        bus.brd_n      = 1'b1;
        bus.bwr_n      = 1'b1;
        bus.bd_oe      = 1'b0;
        bus.ack0       = 1'b0;
        bus.ack1       = 1'b0;
        bus.baddr      = addr_reg;
        bus.bd_out     = wdata_reg;
        bus.rdata      = rdata_reg;
        bus.busy       = (state_reg != S_IDLE);
        case (state_reg)
            S_SETUP, S_STROBE, S_HOLD: begin
                bus.w5300_cs_n = tgt_reg;
                bus.sl811_cs_n = ~tgt_reg;
                bus.bd_oe      = ~rnw_reg;
                if (state_reg == S_STROBE) begin
                    bus.brd_n = ~rnw_reg;
                    bus.bwr_n = rnw_reg;
                end
            end
            S_DONE: begin
                bus.ack0 = ~owner_reg;
                bus.ack1 = owner_reg;
            end
            default: begin
            end
        endcase
    end
endmodule

// File: tb/tb_pbus_sequencer.sv
// Directed and random checks for pbus_sequencer with a per-requester scoreboard.
module tb_pbus_sequencer;
    typedef struct {
        logic       tgt;
        logic       rnw;
        logic [9:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
    } exp_t;

    logic fclk = 1'b0;
    logic rst;
    always #5 fclk = ~fclk;

    pbus_sequencer_if u_if();
    pbus_sequencer_if z_if();

    pbus_sequencer u_dut (.fclk(fclk), .rst(rst), .bus(u_if.master));
    pbus_sequencer #(.SETUP_CYC(0), .W_STROBE_CYC(4), .S_STROBE_CYC(6), .HOLD_CYC(0))
        z_dut (.fclk(fclk), .rst(rst), .bus(z_if.master));

    int checks = 0;
    int errors = 0;

    // Peripheral read model: a fixed byte, or a function of the bus address.
    function automatic logic [7:0] bus_model(input logic [9:0] a);
        return a[7:0] ^ {a[9:8], 6'h2B};
    endfunction

    logic       bd_mode;
    logic [7:0] bd_const;
    assign u_if.bd_in = bd_mode ? bus_model(u_if.baddr) : bd_const;
    assign z_if.bd_in = 8'h00;

    exp_t q0[$];
    exp_t q1[$];
    int   ack_log[$];
    logic got0, got1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Monitor state for the default-timing instance.
    int         stb_cnt, last_stb_len, cs_cnt, last_cs_len;
    logic       stb_rd, last_stb_rd, cs_sl, last_cs_sl, oe_seen, last_oe;
    logic       prev_ack;
    logic [7:0] model_rdata;
    exp_t       mon_e;
    int         mon_who;
    logic       mon_has;

    always @(negedge fclk) begin
        if (rst) begin
            stb_cnt = 0; last_stb_len = 0; cs_cnt = 0; last_cs_len = 0;
            stb_rd = 0; last_stb_rd = 0; cs_sl = 0; last_cs_sl = 0;
            oe_seen = 0; last_oe = 0; prev_ack = 0; model_rdata = 8'h00;
        end else begin
            chk("cs_both_low", 32'(!u_if.w5300_cs_n && !u_if.sl811_cs_n), 0);
            chk("strobe_both_low", 32'(!u_if.brd_n && !u_if.bwr_n), 0);
            chk("strobe_no_cs", 32'((!u_if.brd_n || !u_if.bwr_n) && u_if.w5300_cs_n && u_if.sl811_cs_n), 0);
            chk("oe_no_cs", 32'(u_if.bd_oe && u_if.w5300_cs_n && u_if.sl811_cs_n), 0);
            chk("ack_both", 32'(u_if.ack0 && u_if.ack1), 0);
            if (!u_if.brd_n || !u_if.bwr_n) begin
                stb_cnt++;
                stb_rd = !u_if.brd_n;
            end else if (stb_cnt != 0) begin
                last_stb_len = stb_cnt; last_stb_rd = stb_rd; stb_cnt = 0;
            end
            if (!u_if.w5300_cs_n || !u_if.sl811_cs_n) begin
                cs_cnt++;
                cs_sl   = !u_if.sl811_cs_n;
                oe_seen = oe_seen | u_if.bd_oe;
            end else if (cs_cnt != 0) begin
                last_cs_len = cs_cnt; last_cs_sl = cs_sl; last_oe = oe_seen;
                cs_cnt = 0; oe_seen = 0;
            end
            if (prev_ack) chk("gap_idle", {29'd0, u_if.busy, u_if.ack0, u_if.ack1}, 0);
            if (u_if.ack0 || u_if.ack1) begin
                mon_who = u_if.ack1 ? 1 : 0;
                mon_has = (mon_who == 0) ? (q0.size() != 0) : (q1.size() != 0);
                chk("ack_expected", 32'(mon_has), 1);
                if (mon_has) begin
                    mon_e = (mon_who == 0) ? q0.pop_front() : q1.pop_front();
                    chk("ack_stb_len", 32'(last_stb_len), mon_e.tgt ? 6 : 4);
                    chk("ack_stb_kind", 32'(last_stb_rd), 32'(mon_e.rnw));
                    chk("ack_cs_len", 32'(last_cs_len), mon_e.tgt ? 8 : 6);
                    chk("ack_cs_tgt", 32'(last_cs_sl), 32'(mon_e.tgt));
                    chk("ack_oe", 32'(last_oe), 32'(!mon_e.rnw));
                    chk("ack_baddr", 32'(u_if.baddr), 32'(mon_e.addr));
                    if (!mon_e.rnw) chk("ack_bd_out", 32'(u_if.bd_out), 32'(mon_e.wdata));
                    chk("ack_rdata", 32'(u_if.rdata), mon_e.rnw ? 32'(mon_e.rdata) : 32'(model_rdata));
                    if (mon_e.rnw) model_rdata = mon_e.rdata;
                    $display("ACK req%0d tgt=%0d rnw=%0d addr=%03h rdata=%02h", mon_who,
                             mon_e.tgt, mon_e.rnw, mon_e.addr, u_if.rdata);
                end
                ack_log.push_back(mon_who);
                if (mon_who == 0) got0 = 1'b1; else got1 = 1'b1;
            end
            prev_ack = u_if.ack0 | u_if.ack1;
        end
    end

    task automatic drive_req(input int who, input logic tgt, input logic rnw,
                             input logic [9:0] addr, input logic [7:0] wdata, input logic [7:0] rexp);
        exp_t e;
        e.tgt = tgt; e.rnw = rnw; e.addr = addr; e.wdata = wdata; e.rdata = rexp;
        if (who == 0) begin
            q0.push_back(e);
            u_if.tgt0 = tgt; u_if.rnw0 = rnw; u_if.addr0 = addr; u_if.wdata0 = wdata; u_if.req0 = 1'b1;
        end else begin
            q1.push_back(e);
            u_if.tgt1 = tgt; u_if.rnw1 = rnw; u_if.addr1 = addr; u_if.wdata1 = wdata; u_if.req1 = 1'b1;
        end
    endtask

    task automatic issue(input int who, input bit rnd, input int idx);
        logic       t, r;
        logic [9:0] a;
        logic [7:0] w;
        if (rnd) begin
            t = 1'($urandom_range(1)); r = 1'($urandom_range(1));
            a = 10'($urandom_range(1023)); w = 8'($urandom_range(255));
        end else begin
            t = 1'b0; r = (who == 1);
            a = (who == 1) ? 10'h200 + 10'(idx) : 10'h100 + 10'(idx);
            w = 8'h40 + 8'(idx);
        end
        drive_req(who, t, r, a, w, bus_model(a));
    endtask

    // Two requesters from one loop: drop req the cycle after ack, otherwise maybe re-raise.
    task automatic run_traffic(input int n, input bit rnd);
        int iss, cyc, limit;
        iss = 0; cyc = 0; limit = n * 14 + 200;
        got0 = 1'b0; got1 = 1'b0;
        while ((iss < n || u_if.req0 || u_if.req1) && cyc < limit) begin
            @(posedge fclk); #1;
            cyc++;
            if (u_if.req0 && got0) begin
                u_if.req0 = 1'b0; got0 = 1'b0;
            end else if (!u_if.req0 && iss < n && (!rnd || $urandom_range(3) != 0)) begin
                issue(0, rnd, iss); iss++;
            end
            if (u_if.req1 && got1) begin
                u_if.req1 = 1'b0; got1 = 1'b0;
            end else if (!u_if.req1 && iss < n && (!rnd || $urandom_range(3) != 0)) begin
                issue(1, rnd, iss); iss++;
            end
        end
        chk("traffic_done", 32'(iss == n && !u_if.req0 && !u_if.req1), 1);
        chk("q0_drained", 32'(q0.size()), 0);
        chk("q1_drained", 32'(q1.size()), 0);
    endtask

    task automatic do_reset();
        @(posedge fclk); #1; rst = 1'b1;
        repeat (2) @(posedge fclk);
        #1; rst = 1'b0;
    endtask

    initial begin : stim
        int  k;
        logic seen;
        rst = 1'b1; bd_mode = 1'b0; bd_const = 8'h00; got0 = 1'b0; got1 = 1'b0;
        u_if.req0 = 0; u_if.req1 = 0; u_if.tgt0 = 0; u_if.tgt1 = 0; u_if.rnw0 = 0; u_if.rnw1 = 0;
        u_if.addr0 = 0; u_if.addr1 = 0; u_if.wdata0 = 0; u_if.wdata1 = 0;
        z_if.req0 = 0; z_if.req1 = 0; z_if.tgt0 = 0; z_if.tgt1 = 0; z_if.rnw0 = 0; z_if.rnw1 = 0;
        z_if.addr0 = 0; z_if.addr1 = 0; z_if.wdata0 = 0; z_if.wdata1 = 0;

        // Reset values
        repeat (3) @(posedge fclk);
        @(negedge fclk);
        chk("rst_cs_w", 32'(u_if.w5300_cs_n), 1);
        chk("rst_cs_s", 32'(u_if.sl811_cs_n), 1);
        chk("rst_strobes", {30'd0, u_if.brd_n, u_if.bwr_n}, 3);
        chk("rst_low", {28'd0, u_if.bd_oe, u_if.ack0, u_if.ack1, u_if.busy}, 0);
        chk("rst_baddr", 32'(u_if.baddr), 0);
        chk("rst_bd_out", 32'(u_if.bd_out), 0);
        chk("rst_rdata", 32'(u_if.rdata), 0);
        chk("rst_z_busy", 32'(z_if.busy), 0);
        @(posedge fclk); #1; rst = 1'b0;

        // req0 W5300 write
        @(posedge fclk); #1;
        drive_req(0, 1'b0, 1'b0, 10'h2A5, 8'h5C, 8'h00);
        @(posedge fclk);
        for (k = 0; k < 8; k++) begin
            @(negedge fclk);
            chk("wr_cs_w", 32'(u_if.w5300_cs_n), (k <= 5) ? 0 : 1);
            chk("wr_cs_s", 32'(u_if.sl811_cs_n), 1);
            chk("wr_bwr", 32'(u_if.bwr_n), (k >= 1 && k <= 4) ? 0 : 1);
            chk("wr_brd", 32'(u_if.brd_n), 1);
            chk("wr_oe", 32'(u_if.bd_oe), (k <= 5) ? 1 : 0);
            chk("wr_ack0", 32'(u_if.ack0), (k == 6) ? 1 : 0);
            if (k <= 6) begin
                chk("wr_baddr", 32'(u_if.baddr), 32'h2A5);
                chk("wr_bd_out", 32'(u_if.bd_out), 32'h5C);
            end
            if (k == 6) u_if.req0 = 1'b0;
        end

        // req1 SL811 read
        @(posedge fclk); #1;
        bd_const = 8'hC3;
        drive_req(1, 1'b1, 1'b1, 10'h001, 8'h00, 8'hC3);
        @(posedge fclk);
        for (k = 0; k < 10; k++) begin
            @(negedge fclk);
            chk("rd_cs_s", 32'(u_if.sl811_cs_n), (k <= 7) ? 0 : 1);
            chk("rd_cs_w", 32'(u_if.w5300_cs_n), 1);
            chk("rd_brd", 32'(u_if.brd_n), (k >= 1 && k <= 6) ? 0 : 1);
            chk("rd_bwr", 32'(u_if.bwr_n), 1);
            chk("rd_oe", 32'(u_if.bd_oe), 0);
            chk("rd_ack1", 32'(u_if.ack1), (k == 8) ? 1 : 0);
            if (k == 8) begin
                chk("rd_rdata", 32'(u_if.rdata), 32'hC3);
                u_if.req1 = 1'b0;
            end
        end

        // Reset during the strobe of a read, then a normal read
        @(posedge fclk); #1;
        bd_const = 8'h77;
        u_if.tgt0 = 1'b0; u_if.rnw0 = 1'b1; u_if.addr0 = 10'h033; u_if.req0 = 1'b1;
        seen = 1'b0;
        for (k = 0; k < 20 && !seen; k++) begin
            @(negedge fclk);
            seen = !u_if.brd_n;
        end
        chk("rst_mid_strobe_seen", 32'(seen), 1);
        @(posedge fclk); #1; rst = 1'b1; u_if.req0 = 1'b0;
        @(posedge fclk);
        @(negedge fclk);
        chk("rstmid_strobes", {30'd0, u_if.brd_n, u_if.bwr_n}, 3);
        chk("rstmid_cs", {30'd0, u_if.w5300_cs_n, u_if.sl811_cs_n}, 3);
        chk("rstmid_ack_busy", {29'd0, u_if.ack0, u_if.ack1, u_if.busy}, 0);
        chk("rstmid_rdata", 32'(u_if.rdata), 0);
        @(posedge fclk); #1; rst = 1'b0;
        bd_const = 8'h11;
        drive_req(0, 1'b0, 1'b1, 10'h044, 8'h00, 8'h11);
        seen = 1'b0;
        for (k = 0; k < 20 && !seen; k++) begin
            @(negedge fclk);
            seen = u_if.ack0;
        end
        chk("rst_recover_ack", 32'(seen), 1);
        chk("rst_recover_rdata", 32'(u_if.rdata), 32'h11);
        u_if.req0 = 1'b0;

        // Zero setup/hold instance: strobe right after grant, ack in the 5th cycle
        @(posedge fclk); #1;
        z_if.tgt0 = 1'b0; z_if.rnw0 = 1'b0; z_if.addr0 = 10'h155; z_if.wdata0 = 8'hA3; z_if.req0 = 1'b1;
        @(posedge fclk);
        for (k = 0; k < 6; k++) begin
            @(negedge fclk);
            chk("z_bwr", 32'(z_if.bwr_n), (k <= 3) ? 0 : 1);
            chk("z_cs_w", 32'(z_if.w5300_cs_n), (k <= 3) ? 0 : 1);
            chk("z_ack0", 32'(z_if.ack0), (k == 4) ? 1 : 0);
            chk("z_busy", 32'(z_if.busy), (k <= 4) ? 1 : 0);
            if (k <= 4) chk("z_baddr", 32'(z_if.baddr), 32'h155);
            if (k == 4) z_if.req0 = 1'b0;
        end

        // Simultaneous requests after reset: grant order 0,1,0,1
        do_reset();
        bd_mode = 1'b1;
        ack_log.delete();
        run_traffic(4, 1'b0);
        chk("tie_count", 32'(ack_log.size()), 4);
        for (int i = 0; i < ack_log.size() && i < 4; i++) chk("tie_order", 32'(ack_log[i]), 32'(i % 2));

        // Random mixed traffic
        run_traffic(5000, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
